// File: rtl/mr_wb_arbiter.sv
// mr_wb_arbiter
//   Shares one pipelined Wishbone B4 (stall) slave port between two masters:
//   M0 = load/store unit, M1 = instruction fetch. A master keeps the grant for
//   its whole cycle (cyc high). A watchdog aborts cycles that the slave never
//   answers.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i      master N bus request, strobe, write enable
//   mN_addr_i/sel_i/dat_i    master N word address, byte selects, write data
//   mN_ack_o/err_o/stall_o   responses routed to master N
//   mN_dat_o                 read data to master N (slave data fanned out)
//   s_*_o                    muxed owner request toward the slave
//   s_ack_i/err_i/stall_i    slave responses
//   s_dat_i                  slave read data
//   grant_o                  one-hot owner (00 = idle)
//
// State table
//   state | meaning
//   IDLE  | nobody owns the bus; all masters stalled
//   G0    | M0 owns the slave port
//   G1    | M1 owns the slave port
module mr_wb_arbiter #(
    parameter int XLEN    = 32,
    parameter int AW      = 30,
    parameter int RR      = 1,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [XLEN/8-1:0] m0_sel_i,
    input  logic [XLEN-1:0]   m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_stall_o,
    output logic [XLEN-1:0]   m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [XLEN/8-1:0] m1_sel_i,
    input  logic [XLEN-1:0]   m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_stall_o,
    output logic [XLEN-1:0]   m1_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_addr_o,
    output logic [XLEN/8-1:0] s_sel_o,
    output logic [XLEN-1:0]   s_dat_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_stall_i,
    input  logic [XLEN-1:0]   s_dat_i,

    output logic [1:0]        grant_o
);

    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_n;
    logic           last_grant;   // 0: M0 held the bus last, 1: M1
    logic [WDW-1:0] wd_cnt;
    logic           wd_abort;
    logic           pick_m1;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // On contention, round-robin hands the bus to whoever did not own it last.
    assign pick_m1 = m1_cyc_i && (!m0_cyc_i || ((RR != 0) && !last_grant));

    // An ack in the same cycle as the timeout means the slave did answer.
    always_comb begin
        wd_abort = 1'b0;
        if (TIMEOUT > 0)
            wd_abort = (state != IDLE) && (wd_cnt == WDW'(TIMEOUT)) && !s_ack_i;
    end

    always_comb begin
        state_n    = state;
        grant_o    = 2'b00;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = '0;
        s_sel_o    = '0;
        s_dat_o    = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_stall_o = 1'b1;

        case (state)
            G0: begin
                grant_o    = 2'b01;
                s_cyc_o    = m0_cyc_i & ~wd_abort;
                s_stb_o    = m0_stb_i & ~wd_abort;
                s_we_o     = m0_we_i;
                s_addr_o   = m0_addr_i;
                s_sel_o    = m0_sel_i;
                s_dat_o    = m0_dat_i;
                m0_ack_o   = s_ack_i;
                m0_err_o   = s_err_i | wd_abort;
                m0_stall_o = s_stall_i;
                if (wd_abort)
                    state_n = IDLE;
                else if (!m0_cyc_i)
                    state_n = m1_cyc_i ? G1 : IDLE;
            end
            G1: begin
                grant_o    = 2'b10;
                s_cyc_o    = m1_cyc_i & ~wd_abort;
                s_stb_o    = m1_stb_i & ~wd_abort;
                s_we_o     = m1_we_i;
                s_addr_o   = m1_addr_i;
                s_sel_o    = m1_sel_i;
                s_dat_o    = m1_dat_i;
                m1_ack_o   = s_ack_i;
                m1_err_o   = s_err_i | wd_abort;
                m1_stall_o = s_stall_i;
                if (wd_abort)
                    state_n = IDLE;
                else if (!m1_cyc_i)
                    state_n = m0_cyc_i ? G0 : IDLE;
            end
            default: begin
                if (m0_cyc_i || m1_cyc_i)
                    state_n = pick_m1 ? G1 : G0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            state <= state_n;
            if (state_n != state && state_n != IDLE)
                last_grant <= (state_n == G1);
            // Counter measures silence within one grant; saturates at the abort value.
            if (TIMEOUT == 0 || state_n != state || s_ack_i || s_err_i)
                wd_cnt <= '0;
            else if (s_cyc_o && wd_cnt != WDW'(TIMEOUT))
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule
